// File: rtl/es_rst_key_ctrl.sv
// es_rst_key_ctrl: board reset push-button controller on an Avalon-MM slave port.
// Synchronizes and debounces the raw active-low key, captures press events
// with a maskable level interrupt, and can optionally turn a debounced press
// into a timed active-low software reset request.
// Optional feature macro: ES_RST_KEY_AUTORST_EN (CTRL register + reset FSM).
// Register map: 0 DATA (ro), 1 CTRL (rw), 2 IRQMASK (rw), 3 EDGECAP (ro, write 1 clears).
module es_rst_key_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int RST_PULSE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        irq,
    output logic        rst_req_n
);

    localparam int              DB_W    = 20;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_meta_r;
    logic            sync_q_r;
    logic            stable_r;
    logic            stable_d_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            edgecap_r;
    logic            irqmask_r;
    logic            irq_r;
    logic [31:0]     readdata_r;
    logic [31:0]     rd_mux_s;
    logic            press_s;
    logic            wr_s;
    logic            ctrl_rd_s;
    logic            unused_wdata_s;

    assign wr_s           = chipselect & ~write_n;
    assign press_s        = stable_d_r & ~stable_r;
    assign unused_wdata_s = ^writedata[31:1];

    // Two-flop synchronizer for the asynchronous key level; idles released (1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_r <= 1'b1;
            sync_q_r    <= 1'b1;
        end else begin
            sync_meta_r <= in_port;
            sync_q_r    <= sync_meta_r;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_r   <= 1'b1;
            stable_d_r <= 1'b1;
            db_cnt_r   <= {DB_W{1'b0}};
        end else begin
            stable_d_r <= stable_r;
            if (sync_q_r != stable_r) begin
                if (db_cnt_r == DB_LAST) begin
                    stable_r <= sync_q_r;
                    db_cnt_r <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r <= db_cnt_r + {{(DB_W-1){1'b0}}, 1'b1};
                end
            end else begin
                db_cnt_r <= {DB_W{1'b0}};
            end
        end
    end

    // Edge capture, interrupt mask and registered interrupt; a press beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_r <= 1'b0;
            irqmask_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            irq_r <= edgecap_r & irqmask_r;
            if (press_s) begin
                edgecap_r <= 1'b1;
            end else if (wr_s && (address == 2'd3) && writedata[0]) begin
                edgecap_r <= 1'b0;
            end else begin
                edgecap_r <= edgecap_r;
            end
            if (wr_s && (address == 2'd2)) begin
                irqmask_r <= writedata[0];
            end else begin
                irqmask_r <= irqmask_r;
            end
        end
    end

`ifdef ES_RST_KEY_AUTORST_EN
    localparam logic [7:0] PULSE_LAST = 8'(RST_PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_WAIT_REL = 2'd2
    } rst_state_e;

    rst_state_e state_r;
    logic [7:0] pulse_cnt_r;
    logic       autorst_en_r;
    logic       rst_req_n_r;

    assign ctrl_rd_s = autorst_en_r;
    assign rst_req_n = rst_req_n_r;

    // CTRL register: AUTORST_EN enable bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            autorst_en_r <= 1'b0;
        end else if (wr_s && (address == 2'd1)) begin
            autorst_en_r <= writedata[0];
        end else begin
            autorst_en_r <= autorst_en_r;
        end
    end

    // Reset-request sequencer: one fixed-width pulse per press, re-armed only by a debounced release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            pulse_cnt_r <= 8'd0;
            rst_req_n_r <= 1'b1;
        end else begin
            rst_req_n_r <= (state_r != ST_PULSE);
            case (state_r)
                ST_IDLE: begin
                    if (press_s && autorst_en_r) begin
                        state_r     <= ST_PULSE;
                        pulse_cnt_r <= PULSE_LAST;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt_r == 8'd0) begin
                        state_r <= ST_WAIT_REL;
                    end else begin
                        pulse_cnt_r <= pulse_cnt_r - 8'd1;
                    end
                end
                ST_WAIT_REL: begin
                    if (stable_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_REL;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    pulse_cnt_r <= 8'd0;
                end
            endcase
        end
    end
`else
    assign ctrl_rd_s = 1'b0;
    assign rst_req_n = 1'b1;
`endif

    // Read multiplexer over the four registers; upper bits read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (address)
            2'd0:    rd_mux_s = {30'd0, sync_q_r, stable_r};
            2'd1:    rd_mux_s = {31'd0, ctrl_rd_s};
            2'd2:    rd_mux_s = {31'd0, irqmask_r};
            2'd3:    rd_mux_s = {31'd0, edgecap_r};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, one cycle after the address is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_mux_s;
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_es_rst_key_ctrl.sv
// Self-checking bench for es_rst_key_ctrl (DEBOUNCE_CYCLES=8, RST_PULSE_CYCLES=4).
// A behavioural model tracks the key history and the register effects; a
// compare process checks readdata/irq/rst_req_n every cycle, and directed
// scenarios pin the model with hand-computed values before a random phase.
module tb_es_rst_key_ctrl;

    localparam int DB = 8;
    localparam int NP = 4;
`ifdef ES_RST_KEY_AUTORST_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        in_port = 1'b1;
    logic        irq;
    logic        rst_req_n;

    int checks = 0;
    int failures = 0;

    es_rst_key_ctrl #(.DEBOUNCE_CYCLES(DB), .RST_PULSE_CYCLES(NP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq),
        .rst_req_n  (rst_req_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          in_hist[$];
    bit          sync_hist[$];
    bit          m_stable, m_press_pend, m_edgecap, m_irqmask, m_ctrl, m_irq, m_rst_n, m_busy;
    logic [31:0] m_rdata;
    int          m_cyc, m_pulse_edge;

    task automatic model_reset();
        in_hist.delete();
        in_hist.push_back(1'b1);
        in_hist.push_back(1'b1);
        sync_hist.delete();
        m_stable = 1'b1; m_press_pend = 1'b0; m_edgecap = 1'b0; m_irqmask = 1'b0;
        m_ctrl = 1'b0; m_irq = 1'b0; m_rst_n = 1'b1; m_busy = 1'b0;
        m_rdata = 32'd0; m_cyc = 0; m_pulse_edge = -100;
    endtask

    task automatic model_step();
        bit sync_now, old_edgecap, old_mask, old_ctrl, old_stable, we, all_diff;
        m_cyc++;
        // the key level seen by the logic lags the pin by two clock edges
        sync_now = in_hist[0];
        in_hist.push_back(in_port);
        void'(in_hist.pop_front());
        old_edgecap = m_edgecap; old_mask = m_irqmask; old_ctrl = m_ctrl; old_stable = m_stable;
        we = chipselect && !write_n;
        case (address)
            2'd0:    m_rdata = {30'd0, sync_now, old_stable};
            2'd1:    m_rdata = {31'd0, old_ctrl};
            2'd2:    m_rdata = {31'd0, old_mask};
            default: m_rdata = {31'd0, old_edgecap};
        endcase
        m_irq = old_edgecap & old_mask;
        if (m_press_pend) m_edgecap = 1'b1;
        else if (we && address == 2'd3 && writedata[0]) m_edgecap = 1'b0;
        if (we && address == 2'd2) m_irqmask = writedata[0];
        if (AUTO && we && address == 2'd1) m_ctrl = writedata[0];
        // one pulse per press, then wait for the key to be seen released
        if (m_press_pend && old_ctrl && !m_busy) begin
            m_busy = 1'b1;
            m_pulse_edge = m_cyc;
        end else if (m_busy && m_cyc > m_pulse_edge + NP && old_stable) begin
            m_busy = 1'b0;
        end
        m_rst_n = !(m_cyc >= m_pulse_edge + 1 && m_cyc <= m_pulse_edge + NP);
        // level accepted once the last DB sampled levels all disagree with it
        sync_hist.push_back(sync_now);
        if (sync_hist.size() > DB) void'(sync_hist.pop_front());
        all_diff = (sync_hist.size() == DB);
        foreach (sync_hist[k]) if (sync_hist[k] == old_stable) all_diff = 1'b0;
        if (all_diff) m_stable = ~old_stable;
        m_press_pend = old_stable & ~m_stable;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_n) begin
            check("readdata", readdata, m_rdata);
            check("irq", {31'd0, irq}, {31'd0, m_irq});
            check("rst_req_n", {31'd0, rst_req_n}, {31'd0, m_rst_n});
        end
    end

    // pulse width / pulse count monitor
    int low_cnt = 0;
    int fall_cnt = 0;
    bit prev_rst = 1'b1;
    always @(negedge clk) begin
        if (reset_n) begin
            if (!rst_req_n) low_cnt++;
            if (prev_rst && !rst_req_n) fall_cnt++;
            prev_rst = rst_req_n;
        end else begin
            prev_rst = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        cyc(1);
        check(name, readdata, exp);
    endtask

    initial begin
        int run_left;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);

        // reset values
        rd(2'd0, 32'h3, "rst_data");
        rd(2'd1, 32'h0, "rst_ctrl");
        rd(2'd2, 32'h0, "rst_mask");
        rd(2'd3, 32'h0, "rst_edgecap");
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rst_req_n", {31'd0, rst_req_n}, 32'd1);

        // glitch rejection
        in_port = 1'b0; cyc(5); in_port = 1'b1; cyc(12);
        rd(2'd0, 32'h3, "glitch_stable");
        rd(2'd3, 32'h0, "glitch_edgecap");

        // press with interrupt
        wr(2'd2, 32'h1);
        address = 2'd3;
        in_port = 1'b0;
        cyc(11);
        check("press_irq_c11", {31'd0, irq}, 32'd0);
        cyc(1);
        check("press_edgecap_c12", readdata, 32'h1);
        check("press_irq_c12", {31'd0, irq}, 32'd1);
        cyc(8);
        rd(2'd3, 32'h1, "press_read_edgecap");
        wr(2'd3, 32'h1);
        check("clear_irq_c1", {31'd0, irq}, 32'd1);
        cyc(1);
        check("clear_irq_c2", {31'd0, irq}, 32'd0);
        in_port = 1'b1; cyc(12);

        // set/clear collision on the press-event cycle
        in_port = 1'b0;
        cyc(10);
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h1, "collision_edgecap");
        wr(2'd3, 32'h1);
        in_port = 1'b1; cyc(12);

        // auto reset
        wr(2'd1, 32'h1);
        low_cnt = 0; fall_cnt = 0;
        in_port = 1'b0; cyc(40);
        in_port = 1'b1; cyc(15);
        check("auto_low_cycles", low_cnt, AUTO ? NP : 0);
        check("auto_pulse_count", fall_cnt, AUTO ? 1 : 0);
        in_port = 1'b0; cyc(20);
        check("auto_repress_count", fall_cnt, AUTO ? 2 : 0);
        check("auto_repress_low", low_cnt, AUTO ? 2 * NP : 0);
        in_port = 1'b1; cyc(15);

        // reset during the pulse
        in_port = 1'b0; cyc(13);
        check("midpulse_low", {31'd0, rst_req_n}, AUTO ? 32'd0 : 32'd1);
        check("midpulse_irq_before", {31'd0, irq}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_req_n", {31'd0, rst_req_n}, 32'd1);
        check("async_irq", {31'd0, irq}, 32'd0);
        in_port = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        rd(2'd1, 32'h0, "after_rst_ctrl");
        rd(2'd3, 32'h0, "after_rst_edgecap");
        cyc(12);

        // random phase
        run_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run_left == 0) begin
                in_port = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 20);
            end
            address = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 5) == 0);
            write_n = 1'($urandom_range(0, 1));
            writedata = $urandom;
            cyc(1);
            run_left--;
        end
        chipselect = 1'b0; write_n = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/es_rst_key_ctrl.md
# es_rst_key_ctrl

Controller for the board reset push-button. It synchronizes and debounces the raw active-low key, latches press events into an edge-capture register with a maskable interrupt, and can optionally turn a debounced press into a timed software reset request. It sits beside the ES system's reset-key input port as an Avalon-MM slave on the same interconnect, with the same 2-bit register address space and 1-cycle read latency.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized samples required to accept a level change (1 ms at 50 MHz); legal range 2 to 2^20.
- RST_PULSE_CYCLES, default 16: width of the `rst_req_n` low pulse, in clocks; legal range 1 to 255.

Ports:
- clk, in, 1: system clock; the block has one clock.
- reset_n, in, 1: asynchronous, active-low reset.
- address, in, 2: register select.
- chipselect, in, 1: slave select.
- write_n, in, 1: active-low write strobe; a write is `chipselect & ~write_n`.
- writedata, in, 32: write data.
- readdata, out, 32: registered read data; the unused upper bits read as 0.
- in_port, in, 1: raw key level, asynchronous to `clk`, low when pressed.
- irq, out, 1: registered level interrupt.
- rst_req_n, out, 1: active-low reset request pulse.

## Operation
Register map (only bit 0 is meaningful unless stated):
- Address 0, DATA, read-only: bit 0 = debounced level `stable`; bit 1 = synchronized raw level `sync_q`.
- Address 1, CTRL, read/write: bit 0 = AUTORST_EN. Reset value 0.
- Address 2, IRQMASK, read/write. Reset value 0.
- Address 3, EDGECAP, read-only status. A write with `writedata[0]=1` clears it.

Synchronizer and debounce:
- A 2-flop synchronizer produces `sync_q`; both flops reset to 1.
- `stable` resets to 1. The debounce counter resets to 0.
- Each cycle that `sync_q != stable`, the counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1 and `sync_q` still differs, `stable <= sync_q` and the counter returns to 0.
- Any cycle with `sync_q == stable` clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.

Press event and interrupt:
- A press event is a 1→0 transition of `stable`. It sets EDGECAP on the next edge.
- If a press event and a clearing write occur in the same cycle, set wins.
- `irq <= EDGECAP & IRQMASK`, registered.

Reset FSM (states IDLE, PULSE, WAIT_REL; reset state IDLE):
- IDLE → PULSE on a press event while AUTORST_EN=1. The pulse counter loads RST_PULSE_CYCLES-1.
- PULSE: `rst_req_n=0`. The counter decrements; at 0 the FSM moves to WAIT_REL.
- WAIT_REL → IDLE when `stable=1`, i.e. on debounced release. No retrigger is possible while the key is held.
- Clearing AUTORST_EN mid-PULSE does not truncate the pulse.

Read path:
- `readdata` is registered every cycle from the muxed register. Reads have no side effects.

Reset values: `readdata=0`, `irq=0`, `rst_req_n=1`, EDGECAP=0.

## Timing
- in_port edge to `sync_q`: 2 clocks.
- `sync_q` change to `stable` change: DEBOUNCE_CYCLES clocks, if held steady.
- `stable` fall to EDGECAP=1: 1 clock. To `irq=1`: 2 clocks.
- `stable` fall to `rst_req_n` low: 2 clocks. `rst_req_n` stays low for exactly RST_PULSE_CYCLES clocks.
- Read data is valid 1 clock after the address is presented.
- A write takes effect at the edge on which it is presented.
- Assertion of `reset_n` mid-operation immediately forces all state and outputs to their reset values, including an in-progress pulse (`rst_req_n` returns to 1).

## Configuration
- `ES_RST_KEY_AUTORST_EN` defined: the CTRL register and the reset FSM are compiled in, as described above.
- Not defined:
  - `rst_req_n` is tied to 1.
  - Address 1 reads 0 and writes to it are ignored.
  - The FSM logic is absent.
  - Debounce, EDGECAP, IRQMASK and `irq` behave identically in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and RST_PULSE_CYCLES=4.
- **Reset values:** deassert reset, then read all four addresses → 0x3, 0x0, 0x0, 0x0; `irq=0`, `rst_req_n=1`.
- **Glitch rejection:** `in_port` low for 5 clocks, then high → `stable` stays 1, EDGECAP stays 0.
- **Press with interrupt:** write IRQMASK=1, then hold `in_port` low for 20 clocks.
  - EDGECAP=1 at clock 11; `irq=1` at clock 12.
  - Read address 3 → 0x1.
  - Write 1 to address 3 → `irq` falls 2 clocks later.
- **Set/clear collision:** present the EDGECAP clear write on the exact cycle of the press event → EDGECAP=1.
- **Auto reset:** set CTRL=1, then press and hold for 40 clocks.
  - `rst_req_n` is low for exactly 4 clocks.
  - No second pulse occurs until release plus a re-press.
  - With the macro undefined, `rst_req_n` stays 1 throughout.
- **Reset mid-pulse:** assert `reset_n` during PULSE → `rst_req_n=1` and `irq=0` asynchronously; CTRL reads 0 after release.
